// File: rtl/apu_initiator_pkg.sv
// Types shared by the APU initiator: destination tag and queued result entry.
package apu_initiator_pkg;

    import cv32e40p_apu_core_pkg::*;

    localparam int unsigned TAG_W = 5;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t                        rd;
        logic [31:0]                 data;
        logic [APU_NUSFLAGS_CPU-1:0] flags;
    } result_t;

endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared between the core and its auxiliary processing unit.
package cv32e40p_apu_core_pkg;

    parameter int APU_NARGS_CPU    = 3;
    parameter int APU_WOP_CPU      = 6;
    parameter int APU_NDSFLAGS_CPU = 15;
    parameter int APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/apu_initiator_fifo.sv
// Synchronous FIFO of arbitrary depth and element type with full/empty flags.
module apu_initiator_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= bump(wptr_q);
            if (do_pop)  rptr_q <= bump(rptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/apu_initiator.sv
// Core-side APU initiator: registered request issue, in-order tag/result tracking, writeback.
// Optional sticky fflags accumulator under macro APU_INITIATOR_FFLAGS_EN.
module apu_initiator
    import cv32e40p_apu_core_pkg::*;
    import apu_initiator_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]    cmd_operands_i,
    input  logic [APU_WOP_CPU-1:0]            cmd_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]       cmd_flags_i,
    input  logic [4:0]                        cmd_rd_i,
    output logic                              apu_req_o,
    input  logic                              apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]    apu_operands_o,
    output logic [APU_WOP_CPU-1:0]            apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]       apu_flags_o,
    input  logic                              apu_rvalid_i,
    input  logic [31:0]                       apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]       apu_rflags_i,
    output logic                              wb_valid_o,
    input  logic                              wb_ready_i,
    output logic [4:0]                        wb_rd_o,
    output logic [31:0]                       wb_data_o,
    output logic [APU_NUSFLAGS_CPU-1:0]       wb_flags_o,
    output logic                              busy_o,
    output logic                              spurious_o
`ifdef APU_INITIATOR_FFLAGS_EN
    ,
    output logic [APU_NUSFLAGS_CPU-1:0]       fflags_o,
    input  logic                              fflags_clr_i
`endif
);

    localparam int unsigned CREDIT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CREDIT_W-1:0] credit_q;
    tag_t                req_rd_q;
    logic                spurious_q;
    logic                cmd_hs;
    logic                grant;
    logic                wb_hs;
    logic                tag_push, tag_pop, tag_full, tag_empty;
    tag_t                tag_head;
    logic                res_push, res_full, res_empty;
    result_t             res_in, res_head;

    // Readiness depends on the registered credit only, so a same-cycle writeback cannot reopen it.
    assign cmd_ready_o = (credit_q < CREDIT_W'(MAX_OUTSTANDING)) && (!apu_req_o || apu_gnt_i);
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;
    assign grant       = apu_req_o && apu_gnt_i;
    assign wb_hs       = wb_valid_o && wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            apu_req_o      <= 1'b0;
            apu_operands_o <= '0;
            apu_op_o       <= '0;
            apu_flags_o    <= '0;
            req_rd_q       <= '0;
        end else if (cmd_hs) begin
            apu_req_o      <= 1'b1;
            apu_operands_o <= cmd_operands_i;
            apu_op_o       <= cmd_op_i;
            apu_flags_o    <= cmd_flags_i;
            req_rd_q       <= cmd_rd_i;
        end else if (grant) begin
            apu_req_o      <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
        end else if (cmd_hs && !wb_hs) begin
            credit_q <= credit_q + 1'b1;
        end else if (!cmd_hs && wb_hs) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    // Tag emptiness is the registered view, so a same-cycle grant cannot match a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) spurious_q <= 1'b0;
        else         spurious_q <= apu_rvalid_i && tag_empty;
    end

    assign tag_push = grant && !tag_full;
    assign tag_pop  = apu_rvalid_i && !tag_empty;
    assign res_push = tag_pop && !res_full;
    assign res_in   = '{rd: tag_head, data: apu_rdata_i, flags: apu_rflags_i};

    apu_initiator_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (tag_t)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (tag_push),
        .wdata (req_rd_q),
        .pop   (tag_pop),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    apu_initiator_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (result_t)
    ) u_res_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (res_push),
        .wdata (res_in),
        .pop   (wb_hs),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty)
    );

    assign wb_valid_o = !res_empty;
    assign wb_rd_o    = res_head.rd;
    assign wb_data_o  = res_head.data;
    assign wb_flags_o = res_head.flags;
    assign busy_o     = (credit_q != '0);
    assign spurious_o = spurious_q;

`ifdef APU_INITIATOR_FFLAGS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)           fflags_o <= '0;
        else if (fflags_clr_i) fflags_o <= '0;
        else if (wb_hs)        fflags_o <= fflags_o | wb_flags_o;
    end
`endif

endmodule

// File: tb/tb_apu_initiator.sv
// Directed self-checking bench for apu_initiator (MAX_OUTSTANDING = 2).
module tb_apu_initiator;

    import cv32e40p_apu_core_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              cmd_valid = 1'b0;
    logic                              cmd_ready;
    logic [APU_NARGS_CPU-1:0][31:0]    cmd_operands = '0;
    logic [APU_WOP_CPU-1:0]            cmd_op = '0;
    logic [APU_NDSFLAGS_CPU-1:0]       cmd_flags = '0;
    logic [4:0]                        cmd_rd = '0;
    logic                              apu_req;
    logic                              apu_gnt = 1'b0;
    logic [APU_NARGS_CPU-1:0][31:0]    apu_operands;
    logic [APU_WOP_CPU-1:0]            apu_op;
    logic [APU_NDSFLAGS_CPU-1:0]       apu_flags;
    logic                              apu_rvalid = 1'b0;
    logic [31:0]                       apu_rdata = '0;
    logic [APU_NUSFLAGS_CPU-1:0]       apu_rflags = '0;
    logic                              wb_valid;
    logic                              wb_ready = 1'b1;
    logic [4:0]                        wb_rd;
    logic [31:0]                       wb_data;
    logic [APU_NUSFLAGS_CPU-1:0]       wb_flags;
    logic                              busy;
    logic                              spurious;
`ifdef APU_INITIATOR_FFLAGS_EN
    logic [APU_NUSFLAGS_CPU-1:0]       fflags;
    logic                              fflags_clr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apu_initiator #(.MAX_OUTSTANDING(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_operands_i (cmd_operands),
        .cmd_op_i       (cmd_op),
        .cmd_flags_i    (cmd_flags),
        .cmd_rd_i       (cmd_rd),
        .apu_req_o      (apu_req),
        .apu_gnt_i      (apu_gnt),
        .apu_operands_o (apu_operands),
        .apu_op_o       (apu_op),
        .apu_flags_o    (apu_flags),
        .apu_rvalid_i   (apu_rvalid),
        .apu_rdata_i    (apu_rdata),
        .apu_rflags_i   (apu_rflags),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .wb_flags_o     (wb_flags),
        .busy_o         (busy),
        .spurious_o     (spurious)
`ifdef APU_INITIATOR_FFLAGS_EN
        ,
        .fflags_o       (fflags),
        .fflags_clr_i   (fflags_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        chk("rst_req", apu_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spur", spurious, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_op", apu_op, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Single ADD: rd=5, grant on first request cycle, result 0x40400000
        cmd_valid = 1'b1; cmd_rd = 5'd5; cmd_op = 6'd0;
        cmd_operands[0] = 32'h3F800000; cmd_operands[1] = 32'h40000000;
        #1 chk("t1_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; apu_gnt = 1'b1;
        #1;
        chk("t1_req", apu_req, 1);
        chk("t1_op", apu_op, 0);
        chk("t1_opnd0", apu_operands[0], 32'h3F800000);
        chk("t1_ready_c1", cmd_ready, 1);
        tick();
        apu_gnt = 1'b0;
        #1;
        chk("t1_req_off", apu_req, 0);
        chk("t1_busy", busy, 1);
        tick();
        apu_rvalid = 1'b1; apu_rdata = 32'h40400000;
        #1 chk("t1_wbv_early", wb_valid, 0);
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t1_wbv", wb_valid, 1);
        chk("t1_wbrd", wb_rd, 5);
        chk("t1_wbdata", wb_data, 32'h40400000);
        tick();
        #1;
        chk("t1_wbv_done", wb_valid, 0);
        chk("t1_idle", busy, 0);

        // Grant stall: payload held for 4 cycles, a pending new command is refused
        cmd_valid = 1'b1; cmd_rd = 5'd3; cmd_op = 6'h2A; cmd_operands[0] = 32'h12345678;
        tick();
        cmd_rd = 5'd7; cmd_op = 6'h11; cmd_operands[0] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req", apu_req, 1);
            chk("t2_op", apu_op, 32'h2A);
            chk("t2_opnd0", apu_operands[0], 32'h12345678);
            chk("t2_ready", cmd_ready, 0);
            tick();
        end
        cmd_valid = 1'b0; apu_gnt = 1'b1;
        tick();
        apu_gnt = 1'b0; apu_rvalid = 1'b1; apu_rdata = 32'h33;
        #1 chk("t2_req_off", apu_req, 0);
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t2_wbrd", wb_rd, 3);
        chk("t2_wbdata", wb_data, 32'h33);
        tick();
        #1 chk("t2_idle", busy, 0);

        // Two in flight, writeback stalled: ordering and full credit
        wb_ready = 1'b0;
        cmd_valid = 1'b1; cmd_rd = 5'd1; cmd_op = 6'd1;
        tick();
        cmd_rd = 5'd2; cmd_op = 6'd2; apu_gnt = 1'b1;
        #1;
        chk("t3_b2b_ready", cmd_ready, 1);
        chk("t3_op1", apu_op, 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("t3_req_b2b", apu_req, 1);
        chk("t3_op2", apu_op, 2);
        chk("t3_full", cmd_ready, 0);
        tick();
        apu_gnt = 1'b0; apu_rvalid = 1'b1; apu_rdata = 32'hA;
        tick();
        apu_rdata = 32'hB;
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t3_wbv", wb_valid, 1);
        chk("t3_rd1", wb_rd, 1);
        chk("t3_data1", wb_data, 32'hA);
        chk("t3_full2", cmd_ready, 0);
        tick();
        #1 chk("t3_hold", wb_data, 32'hA);
        wb_ready = 1'b1;
        #1 chk("t3_no_comb_ready", cmd_ready, 0);
        tick();
        #1;
        chk("t3_rd2", wb_rd, 2);
        chk("t3_data2", wb_data, 32'hB);
        chk("t3_ready_back", cmd_ready, 1);
        tick();
        #1;
        chk("t3_wbv_done", wb_valid, 0);
        chk("t3_idle", busy, 0);

        // Response with nothing in flight
        apu_rvalid = 1'b1; apu_rdata = 32'h99;
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t4_spur", spurious, 1);
        chk("t4_wbv", wb_valid, 0);
        chk("t4_busy", busy, 0);
        tick();
        #1 chk("t4_spur_pulse", spurious, 0);

        // Grant and response in the same cycle with empty tag FIFO
        cmd_valid = 1'b1; cmd_rd = 5'd9;
        tick();
        cmd_valid = 1'b0; apu_gnt = 1'b1; apu_rvalid = 1'b1; apu_rdata = 32'h55;
        tick();
        apu_gnt = 1'b0; apu_rdata = 32'h66;
        #1;
        chk("t5_spur", spurious, 1);
        chk("t5_wbv", wb_valid, 0);
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t5_rd", wb_rd, 9);
        chk("t5_data", wb_data, 32'h66);
        chk("t5_nospur", spurious, 0);
        tick();
        #1 chk("t5_idle", busy, 0);

        // Reset with two ops in flight; late response is spurious
        wb_ready = 1'b0;
        cmd_valid = 1'b1; cmd_rd = 5'd4; cmd_op = 6'h3;
        tick();
        cmd_rd = 5'd6; apu_gnt = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        apu_gnt = 1'b0;
        #1 chk("t6_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", apu_req, 0);
        chk("t6_wbv", wb_valid, 0);
        chk("t6_busy0", busy, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_op", apu_op, 0);
        tick();
        rst_n = 1'b1; apu_rvalid = 1'b1; apu_rdata = 32'h77;
        tick();
        apu_rvalid = 1'b0;
        #1;
        chk("t6_late_spur", spurious, 1);
        chk("t6_late_wbv", wb_valid, 0);
        wb_ready = 1'b1;

`ifdef APU_INITIATOR_FFLAGS_EN
        // Sticky flags accumulate across writebacks and clear on request
        chk("t7_ff_rst", fflags, 0);
        cmd_valid = 1'b1; cmd_rd = 5'd10; apu_gnt = 1'b1;
        tick();
        cmd_rd = 5'd11;
        tick();
        cmd_valid = 1'b0;
        tick();
        apu_gnt = 1'b0; apu_rvalid = 1'b1; apu_rflags = 5'h01;
        tick();
        apu_rflags = 5'h10;
        tick();
        apu_rvalid = 1'b0; apu_rflags = '0;
        tick(); tick(); tick();
        #1 chk("t7_ff_acc", fflags, 32'h11);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        #1 chk("t7_ff_clr", fflags, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
